ahb_apb_bridge_p: RTL

AHB_APB_BRIDGE_P -- requirements
Module: ahb_apb_bridge_p

---
 rtl/ahb_apb_pkg.sv | 33 +++
 rtl/apb_slv_decode.sv | 34 +++
 rtl/ahb_apb_bridge_p.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/ahb_apb_pkg.sv
// Shared encodings, FSM states and parameter defaults for the AHB-to-APB bridge.
package ahb_apb_pkg;

   typedef enum logic [1:0] {
      HTRANS_IDLE   = 2'b00,
      HTRANS_BUSY   = 2'b01,
      HTRANS_NONSEQ = 2'b10,
      HTRANS_SEQ    = 2'b11
   } htrans_e;

   typedef enum logic [1:0] {
      HRESP_OKAY  = 2'b00,
      HRESP_ERROR = 2'b01
   } hresp_e;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LATCH,
      ST_SETUP,
      ST_ACCESS,
      ST_DONE,
      ST_ERR1,
      ST_ERR2
   } state_e;

   localparam int unsigned DEF_ADDR_W      = 32;
   localparam int unsigned DEF_DATA_W      = 32;
   localparam int unsigned DEF_NUM_SLV     = 3;
   localparam logic [31:0] DEF_BASE_ADDR   = 32'h8000_0000;
   localparam int unsigned DEF_SLV_SPAN    = 12;
   localparam int unsigned DEF_TIMEOUT_CYC = 64;

endpackage

// File: rtl/apb_slv_decode.sv
// Combinational slave-index decode and transfer-size check for the bridge window.
module apb_slv_decode
   import ahb_apb_pkg::*;
#(
   parameter int unsigned       ADDR_W    = DEF_ADDR_W,
   parameter int unsigned       DATA_W    = DEF_DATA_W,
   parameter int unsigned       NUM_SLV   = DEF_NUM_SLV,
   parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(DEF_BASE_ADDR),
   parameter int unsigned       SLV_SPAN  = DEF_SLV_SPAN,
   localparam int unsigned      IDX_W     = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1
) (
   input  logic [ADDR_W-1:0] haddr,
   input  logic [2:0]        hsize,
   output logic [IDX_W-1:0]  idx,
   output logic              bad
);

   localparam int unsigned LOG2B = $clog2(DATA_W / 8);

   logic [ADDR_W-1:0] offset;
   logic [ADDR_W-1:0] slot;
   logic              miss;
   logic              size_err;

   always_comb begin
      offset   = haddr - BASE_ADDR;
      slot     = offset >> SLV_SPAN;
      miss     = (haddr < BASE_ADDR) || (slot >= ADDR_W'(NUM_SLV));
      size_err = hsize > 3'(LOG2B);
      idx      = slot[IDX_W-1:0];
      bad      = miss || size_err;
   end

endmodule

// File: rtl/ahb_apb_bridge_p.sv
// AHB-Lite to APB bridge with one-hot slave select.
// Optional ACCESS watchdog enabled by defining BRIDGE_TIMEOUT_EN.
module ahb_apb_bridge_p
   import ahb_apb_pkg::*;
#(
   parameter int unsigned       ADDR_W      = DEF_ADDR_W,
   parameter int unsigned       DATA_W      = DEF_DATA_W,
   parameter int unsigned       NUM_SLV     = DEF_NUM_SLV,
   parameter logic [ADDR_W-1:0] BASE_ADDR   = ADDR_W'(DEF_BASE_ADDR),
   parameter int unsigned       SLV_SPAN    = DEF_SLV_SPAN,
   parameter int unsigned       TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
   input  logic                      hclk,
   input  logic                      hreset,
   input  logic                      hsel,
   input  logic [ADDR_W-1:0]         haddr,
   input  logic [1:0]                htrans,
   input  logic                      hwrite,
   input  logic [2:0]                hsize,
   input  logic [DATA_W-1:0]         hwdata,
   input  logic                      hready_in,
   output logic                      hreadyout,
   output logic [1:0]                hresp,
   output logic [DATA_W-1:0]         hrdata,
   output logic [NUM_SLV-1:0]        psel,
   output logic                      penable,
   output logic                      pwrite,
   output logic [ADDR_W-1:0]         paddr,
   output logic [DATA_W-1:0]         pwdata,
   output logic [DATA_W/8-1:0]       pstrb,
   input  logic [NUM_SLV*DATA_W-1:0] prdata,
   input  logic [NUM_SLV-1:0]        pready,
   input  logic [NUM_SLV-1:0]        pslverr
);

   localparam int unsigned STRB_W = DATA_W / 8;
   localparam int unsigned LOG2B  = $clog2(STRB_W);
   localparam int unsigned IDX_W  = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;

   if (DATA_W != 32 && DATA_W != 64) begin : g_chk_data_w
      $error("DATA_W must be 32 or 64");
   end
   if (NUM_SLV < 1 || NUM_SLV > 16) begin : g_chk_num_slv
      $error("NUM_SLV must be in 1..16");
   end
   if (TIMEOUT_CYC < 1) begin : g_chk_timeout
      $error("TIMEOUT_CYC must be at least 1");
   end

   state_e            state, state_nx;
   logic [IDX_W-1:0]  idx_dec, idx_q;
   logic              bad_dec;
   logic              accept;
   logic              sel_ready, sel_err;
   logic [DATA_W-1:0] sel_rdata;
   logic [STRB_W-1:0] strb_nx;
   logic              timeout;
   int unsigned       lane, nbytes;

   apb_slv_decode #(
      .ADDR_W    (ADDR_W),
      .DATA_W    (DATA_W),
      .NUM_SLV   (NUM_SLV),
      .BASE_ADDR (BASE_ADDR),
      .SLV_SPAN  (SLV_SPAN)
   ) u_decode (
      .haddr (haddr),
      .hsize (hsize),
      .idx   (idx_dec),
      .bad   (bad_dec)
   );

   always_comb begin
      accept = hsel && hready_in
               && (htrans == HTRANS_NONSEQ || htrans == HTRANS_SEQ)
               && (state == ST_IDLE || state == ST_DONE || state == ST_ERR2);
      lane    = 32'(haddr[LOG2B-1:0]);
      nbytes  = 32'd1 << hsize;
      strb_nx = '0;
      for (int unsigned b = 0; b < STRB_W; b++) begin
         if (hwrite && b >= lane && b < lane + nbytes) strb_nx[b] = 1'b1;
      end
   end

   // Only the registered slave index steers the response and select lines.
   always_comb begin
      sel_ready = 1'b0;
      sel_err   = 1'b0;
      sel_rdata = '0;
      psel      = '0;
      for (int unsigned s = 0; s < NUM_SLV; s++) begin
         if (idx_q == IDX_W'(s)) begin
            sel_ready = pready[s];
            sel_err   = pslverr[s];
            sel_rdata = prdata[s*DATA_W +: DATA_W];
            psel[s]   = (state == ST_SETUP || state == ST_ACCESS);
         end
      end
   end

`ifdef BRIDGE_TIMEOUT_EN
   localparam int unsigned WD_W = $clog2(TIMEOUT_CYC + 1);
   logic [WD_W-1:0] wd_cnt;

   always_ff @(posedge hclk or posedge hreset) begin
      if (hreset)                  wd_cnt <= '0;
      else if (state == ST_ACCESS) wd_cnt <= wd_cnt + WD_W'(1);
      else                         wd_cnt <= '0;
   end

   always_comb timeout = (wd_cnt == WD_W'(TIMEOUT_CYC - 1)) && !sel_ready;
`else
   always_comb timeout = 1'b0;
`endif

   always_comb begin
      state_nx = state;
      unique case (state)
         ST_IDLE, ST_DONE, ST_ERR2:
            state_nx = accept ? (bad_dec ? ST_ERR1 : ST_LATCH) : ST_IDLE;
         ST_LATCH: state_nx = ST_SETUP;
         ST_SETUP: state_nx = ST_ACCESS;
         ST_ACCESS: begin
            if (sel_ready)    state_nx = sel_err ? ST_ERR1 : ST_DONE;
            else if (timeout) state_nx = ST_ERR1;
         end
         ST_ERR1:  state_nx = ST_ERR2;
         default:  state_nx = ST_IDLE;
      endcase
   end

   always_comb begin
      hreadyout = (state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERR2);
      hresp     = (state == ST_ERR1 || state == ST_ERR2) ? HRESP_ERROR : HRESP_OKAY;
      penable   = (state == ST_ACCESS);
   end

   always_ff @(posedge hclk or posedge hreset) begin
      if (hreset) begin
         state  <= ST_IDLE;
         idx_q  <= '0;
         paddr  <= '0;
         pwrite <= 1'b0;
         pstrb  <= '0;
         pwdata <= '0;
         hrdata <= '0;
      end else begin
         state <= state_nx;
         if (accept) begin
            paddr  <= haddr;
            pwrite <= hwrite;
            pstrb  <= strb_nx;
            idx_q  <= idx_dec;
            hrdata <= '0;
         end
         if (state == ST_LATCH) pwdata <= hwdata;
         if (state == ST_ACCESS && sel_ready && !sel_err && !pwrite) hrdata <= sel_rdata;
      end
   end

endmodule
